// File: rtl/clkgen_pkg.sv
// Shared definitions for the multi-channel fractional clock-enable generator:
// sequencer encoding, default widths and the channel-index width helper.
package clkgen_pkg;

  typedef enum logic {
    LOCKING = 1'b0,
    RUN     = 1'b1
  } seq_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_ACC_W       = 24;
  localparam int DEF_LOCK_CYCLES = 1024;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    if (num_ch > 1) begin
      return $clog2(num_ch);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/clkgen_ch.sv
// One fractional clock-enable channel: phase accumulator, pending/active
// increment pair with glitch-free retune, registered ce and square wave.
module clkgen_ch
  import clkgen_pkg::*;
#(
  parameter int               ACC_W     = DEF_ACC_W,
  parameter logic [ACC_W-1:0] INC_RESET = {ACC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             ce,
  output logic             clk_out
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] inc_pending_r;
  logic [ACC_W-1:0] inc_active_r;
  logic             ce_r;
  logic             clk_out_r;

  logic [ACC_W:0]   sum_s;
  logic             carry_s;
  logic             retune_s;
  logic [ACC_W-1:0] inc_nxt_s;

  // Phase step and retune decision; a same-cycle write bypasses the pending register.
  always_comb begin
    sum_s    = {1'b0, acc_r} + {1'b0, inc_active_r};
    carry_s  = sum_s[ACC_W];
    retune_s = (run & carry_s) | ~run | (inc_active_r == {ACC_W{1'b0}});
    if (!retune_s) begin
      inc_nxt_s = inc_active_r;
    end else if (wr) begin
      inc_nxt_s = wr_inc;
    end else begin
      inc_nxt_s = inc_pending_r;
    end
  end

  // Accumulator, increment registers and output flops; idle channels park at phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r         <= {ACC_W{1'b0}};
      inc_pending_r <= INC_RESET;
      inc_active_r  <= INC_RESET;
      ce_r          <= 1'b0;
      clk_out_r     <= 1'b0;
    end else begin
      inc_active_r <= inc_nxt_s;
      if (wr) begin
        inc_pending_r <= wr_inc;
      end else begin
        inc_pending_r <= inc_pending_r;
      end
      if (run) begin
        acc_r     <= sum_s[ACC_W-1:0];
        ce_r      <= carry_s;
        clk_out_r <= clk_out_r ^ carry_s;
      end else begin
        acc_r     <= {ACC_W{1'b0}};
        ce_r      <= 1'b0;
        clk_out_r <= 1'b0;
      end
    end
  end

  assign ce      = ce_r;
  assign clk_out = clk_out_r;

endmodule

// File: rtl/clkgen.sv
// Multi-channel fractional clock-enable generator: power-up lock sequencer,
// increment write decode and NUM_CH accumulator channels.
module clkgen
  import clkgen_pkg::*;
#(
  parameter int               NUM_CH      = DEF_NUM_CH,
  parameter int               ACC_W       = DEF_ACC_W,
  parameter int               LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter logic [ACC_W-1:0] INC_RESET   = {ACC_W{1'b0}}
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
  input  logic [ACC_W-1:0]            wr_inc,
  input  logic [NUM_CH-1:0]           ch_en,
  output logic [NUM_CH-1:0]           ce,
  output logic [NUM_CH-1:0]           clk_out,
  output logic                        ready
);

  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic             ready_s;
  logic             ready_r;

  // Sequencer state register and lock counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= LOCKING;
      lock_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == LOCKING) && (lock_cnt_r != LOCK_LAST)) begin
        lock_cnt_r <= lock_cnt_r + 1'b1;
      end else begin
        lock_cnt_r <= lock_cnt_r;
      end
    end
  end

  // Sequencer next state; RUN is only left through reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOCKING: begin
        if (lock_cnt_r == LOCK_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LOCKING;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = LOCKING;
    endcase
  end

  // Sequencer output decode.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      LOCKING: ready_s = 1'b0;
      RUN:     ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Registered ready, one edge after entering RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= ready_s;
    end
  end

  assign ready = ready_r;

  // Out-of-range wr_ch values match no channel and are dropped here.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_sel_s;
    logic run_s;
    assign wr_sel_s = wr_en & (wr_ch == CH_W'(g));
    assign run_s    = ready_r & ch_en[g];

    clkgen_ch #(
      .ACC_W     (ACC_W),
      .INC_RESET (INC_RESET)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run_s),
      .wr      (wr_sel_s),
      .wr_inc  (wr_inc),
      .ce      (ce[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule
